// File: rtl/demod_conj_mult_mc_pkg.sv
// Shared types and fixed-point helpers for the conjugate-multiply demodulator stage.
// Helpers work on a wide signed container so any DATA_WIDTH up to 64 fits exactly.
package demod_conj_mult_mc_pkg;

  localparam int QUANT_BITS_DEF = 10;
  localparam int DQ_W = 130;

  typedef logic signed [DQ_W-1:0] wide_t;

  typedef enum logic {
    OREG_EMPTY = 1'b0,
    OREG_VALID = 1'b1
  } oreg_state_e;

  localparam wide_t WIDE_ONE = wide_t'(1'b1);

  // Division by 2^q rounding toward zero: negative values are biased before the shift.
  function automatic wide_t dequant(input wide_t x, input int unsigned q);
    wide_t bias_v;
    bias_v = (WIDE_ONE <<< q) - WIDE_ONE;
    if (x[DQ_W-1]) begin
      dequant = (x + bias_v) >>> q;
    end else begin
      dequant = x >>> q;
    end
  endfunction

  function automatic wide_t saturate(input wide_t x, input int unsigned w);
    wide_t max_v;
    wide_t min_v;
    max_v = (WIDE_ONE <<< (w - 32'd1)) - WIDE_ONE;
    min_v = -max_v - WIDE_ONE;
    if (x > max_v) begin
      saturate = max_v;
    end else if (x < min_v) begin
      saturate = min_v;
    end else begin
      saturate = x;
    end
  endfunction

endpackage

// File: rtl/demod_conj_mult_mc_conj_mult_dq.sv
// Combinational datapath: (re + j*im) * conj(pr + j*pi), each product dequantized
// separately before the sum, then clamped or wrapped to DATA_WIDTH.
module demod_conj_mult_mc_conj_mult_dq
  import demod_conj_mult_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = QUANT_BITS_DEF,
  parameter int SATURATE   = 0
) (
  input  logic signed [DATA_WIDTH-1:0] re_s,
  input  logic signed [DATA_WIDTH-1:0] im_s,
  input  logic signed [DATA_WIDTH-1:0] pr_s,
  input  logic signed [DATA_WIDTH-1:0] pi_s,
  output logic signed [DATA_WIDTH-1:0] r_s,
  output logic signed [DATA_WIDTH-1:0] i_s
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int unsigned QB = QUANT_BITS;
  localparam int unsigned DW = DATA_WIDTH;

  logic signed [PW-1:0] re_x_s, im_x_s, pr_x_s, npi_x_s;
  logic signed [PW-1:0] p_pr_re_s, p_npi_im_s, p_pr_im_s, p_npi_re_s;
  wide_t r_sum_s, i_sum_s;

  assign re_x_s  = PW'(re_s);
  assign im_x_s  = PW'(im_s);
  assign pr_x_s  = PW'(pr_s);
  // Negating at full product width keeps -(-2^(W-1)) representable.
  assign npi_x_s = -PW'(pi_s);

  assign p_pr_re_s  = pr_x_s * re_x_s;
  assign p_npi_im_s = npi_x_s * im_x_s;
  assign p_pr_im_s  = pr_x_s * im_x_s;
  assign p_npi_re_s = npi_x_s * re_x_s;

  assign r_sum_s = dequant(wide_t'(p_pr_re_s), QB) - dequant(wide_t'(p_npi_im_s), QB);
  assign i_sum_s = dequant(wide_t'(p_pr_im_s), QB) + dequant(wide_t'(p_npi_re_s), QB);

  assign r_s = (SATURATE != 0) ? DATA_WIDTH'(saturate(r_sum_s, DW)) : DATA_WIDTH'(r_sum_s);
  assign i_s = (SATURATE != 0) ? DATA_WIDTH'(saturate(i_sum_s, DW)) : DATA_WIDTH'(i_sum_s);

endmodule

// File: rtl/demod_conj_mult_mc.sv
// Multi-channel conjugate-multiply demodulator front stage between I/Q FIFOs and qarctan.
// One sample per cycle, single output register with stall, per-channel previous-sample state.
module demod_conj_mult_mc
  import demod_conj_mult_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = QUANT_BITS_DEF,
  parameter int NUM_CH     = 1,
  parameter int SATURATE   = 0,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_prev,
  output logic                         in_real_rd_en,
  input  logic                         in_real_empty,
  input  logic signed [DATA_WIDTH-1:0] in_real_dout,
  output logic                         in_imag_rd_en,
  input  logic                         in_imag_empty,
  input  logic signed [DATA_WIDTH-1:0] in_imag_dout,
  output logic                         out_real_wr_en,
  input  logic                         out_real_full,
  output logic signed [DATA_WIDTH-1:0] out_real_din,
  output logic                         out_imag_wr_en,
  input  logic                         out_imag_full,
  output logic signed [DATA_WIDTH-1:0] out_imag_din,
  output logic [CH_W-1:0]              out_ch
);

  localparam int NSLOT = 2 ** CH_W;

  oreg_state_e state_r, state_next_s;
  logic [CH_W-1:0] ptr_r, cur_ch_s, ptr_next_s;
  logic signed [DATA_WIDTH-1:0] prev_real_r [NSLOT];
  logic signed [DATA_WIDTH-1:0] prev_imag_r [NSLOT];
  logic signed [DATA_WIDTH-1:0] pr_s, pi_s, r_s, i_s;
  logic avail_s, can_wr_s, out_valid_s, accept_s;

  assign avail_s     = !in_real_empty && !in_imag_empty;
  assign can_wr_s    = !out_real_full && !out_imag_full;
  assign out_valid_s = (state_r == OREG_VALID);
  // Gating with reset keeps both pops low while reset is held.
  assign accept_s    = !reset && avail_s && (!out_valid_s || can_wr_s);

  assign in_real_rd_en  = accept_s;
  assign in_imag_rd_en  = accept_s;
  assign out_real_wr_en = out_valid_s && can_wr_s;
  assign out_imag_wr_en = out_valid_s && can_wr_s;

  // Operand select: a coincident clear makes this sample channel 0 with zero history.
  always_comb begin
    cur_ch_s = '0;
    pr_s     = '0;
    pi_s     = '0;
    if (clear_prev) begin
      cur_ch_s = '0;
      pr_s     = '0;
      pi_s     = '0;
    end else begin
      cur_ch_s = ptr_r;
      pr_s     = prev_real_r[ptr_r];
      pi_s     = prev_imag_r[ptr_r];
    end
  end

  // Channel pointer advance with wrap at NUM_CH.
  always_comb begin
    ptr_next_s = cur_ch_s;
    if (accept_s) begin
      if (cur_ch_s == CH_W'(NUM_CH - 32'sd1)) begin
        ptr_next_s = '0;
      end else begin
        ptr_next_s = cur_ch_s + CH_W'(1'b1);
      end
    end else begin
      ptr_next_s = cur_ch_s;
    end
  end

  // Output register occupancy: EMPTY/VALID.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      OREG_EMPTY: begin
        if (accept_s) begin
          state_next_s = OREG_VALID;
        end else begin
          state_next_s = OREG_EMPTY;
        end
      end
      OREG_VALID: begin
        if (can_wr_s && !accept_s) begin
          state_next_s = OREG_EMPTY;
        end else begin
          state_next_s = OREG_VALID;
        end
      end
      default: state_next_s = OREG_EMPTY;
    endcase
  end

  demod_conj_mult_mc_conj_mult_dq #(
    .DATA_WIDTH(DATA_WIDTH),
    .QUANT_BITS(QUANT_BITS),
    .SATURATE  (SATURATE)
  ) u_conj_mult_dq (
    .re_s(in_real_dout),
    .im_s(in_imag_dout),
    .pr_s(pr_s),
    .pi_s(pi_s),
    .r_s (r_s),
    .i_s (i_s)
  );

  // State register and channel pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= OREG_EMPTY;
      ptr_r   <= '0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
    end
  end

  // Output register: loads on every accept, otherwise holds (covers stall).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_real_din <= '0;
      out_imag_din <= '0;
      out_ch       <= '0;
    end else if (accept_s) begin
      out_real_din <= r_s;
      out_imag_din <= i_s;
      out_ch       <= cur_ch_s;
    end
  end

  // Per-channel history; the accepted sample write overrides a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NSLOT; c++) begin
        prev_real_r[c] <= '0;
        prev_imag_r[c] <= '0;
      end
    end else begin
      if (clear_prev) begin
        for (int c = 0; c < NSLOT; c++) begin
          prev_real_r[c] <= '0;
          prev_imag_r[c] <= '0;
        end
      end
      if (accept_s) begin
        prev_real_r[cur_ch_s] <= in_real_dout;
        prev_imag_r[cur_ch_s] <= in_imag_dout;
      end
    end
  end

endmodule

// File: tb/tb_demod_conj_mult_mc.sv
// Directed bench: single-channel, two-channel and 16-bit saturate/wrap instances
// fed from small array-backed FIFO models, with results logged per write.
module tb_demod_conj_mult_mc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic zero = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Harness A: NUM_CH=1, 32-bit
  logic signed [31:0] a_src_re [64];
  logic signed [31:0] a_src_im [64];
  int a_wr = 0, a_rd = 0, a_n = 0;
  logic a_full_r = 1'b0, a_full_i = 1'b0;
  logic a_empty, a_rd_en_r, a_rd_en_i, a_wr_en_r, a_wr_en_i;
  logic signed [31:0] a_dout_re, a_dout_im, a_out_re, a_out_im;
  logic [0:0] a_out_ch;
  logic signed [31:0] a_res_re [64];
  logic signed [31:0] a_res_im [64];
  int a_res_cyc [64];
  int a_rd_cyc [64];
  assign a_empty   = (a_wr == a_rd);
  assign a_dout_re = a_src_re[a_rd[5:0]];
  assign a_dout_im = a_src_im[a_rd[5:0]];

  // Harness B: NUM_CH=2, 32-bit
  logic signed [31:0] b_src_re [64];
  logic signed [31:0] b_src_im [64];
  int b_wr = 0, b_rd = 0, b_n = 0;
  logic b_clear = 1'b0;
  logic b_empty, b_rd_en_r, b_rd_en_i, b_wr_en_r, b_wr_en_i;
  logic signed [31:0] b_dout_re, b_dout_im, b_out_re, b_out_im;
  logic [0:0] b_out_ch;
  logic signed [31:0] b_res_re [64];
  logic signed [31:0] b_res_im [64];
  logic [0:0] b_res_ch [64];
  assign b_empty   = (b_wr == b_rd);
  assign b_dout_re = b_src_re[b_rd[5:0]];
  assign b_dout_im = b_src_im[b_rd[5:0]];

  // Harness C: 16-bit, SATURATE=1 and SATURATE=0 sharing one source
  logic signed [15:0] c_src_re [8];
  logic signed [15:0] c_src_im [8];
  int c_wr = 0, c_rd = 0, c_n = 0;
  logic c_empty;
  logic cs_rd_en_r, cs_rd_en_i, cs_wr_en_r, cs_wr_en_i;
  logic cw_rd_en_r, cw_rd_en_i, cw_wr_en_r, cw_wr_en_i;
  logic signed [15:0] c_dout_re, c_dout_im, cs_out_re, cs_out_im, cw_out_re, cw_out_im;
  logic [0:0] cs_out_ch, cw_out_ch;
  logic signed [15:0] cs_res_re [8];
  logic signed [15:0] cs_res_im [8];
  logic signed [15:0] cw_res_re [8];
  logic signed [15:0] cw_res_im [8];
  assign c_empty   = (c_wr == c_rd);
  assign c_dout_re = c_src_re[c_rd[2:0]];
  assign c_dout_im = c_src_im[c_rd[2:0]];

  demod_conj_mult_mc #(.DATA_WIDTH(32), .QUANT_BITS(10), .NUM_CH(1), .SATURATE(0)) dut_a (
    .clock(clk), .reset(reset), .clear_prev(zero),
    .in_real_rd_en(a_rd_en_r), .in_real_empty(a_empty), .in_real_dout(a_dout_re),
    .in_imag_rd_en(a_rd_en_i), .in_imag_empty(a_empty), .in_imag_dout(a_dout_im),
    .out_real_wr_en(a_wr_en_r), .out_real_full(a_full_r), .out_real_din(a_out_re),
    .out_imag_wr_en(a_wr_en_i), .out_imag_full(a_full_i), .out_imag_din(a_out_im),
    .out_ch(a_out_ch));

  demod_conj_mult_mc #(.DATA_WIDTH(32), .QUANT_BITS(10), .NUM_CH(2), .SATURATE(0)) dut_b (
    .clock(clk), .reset(reset), .clear_prev(b_clear),
    .in_real_rd_en(b_rd_en_r), .in_real_empty(b_empty), .in_real_dout(b_dout_re),
    .in_imag_rd_en(b_rd_en_i), .in_imag_empty(b_empty), .in_imag_dout(b_dout_im),
    .out_real_wr_en(b_wr_en_r), .out_real_full(zero), .out_real_din(b_out_re),
    .out_imag_wr_en(b_wr_en_i), .out_imag_full(zero), .out_imag_din(b_out_im),
    .out_ch(b_out_ch));

  demod_conj_mult_mc #(.DATA_WIDTH(16), .QUANT_BITS(10), .NUM_CH(1), .SATURATE(1)) dut_cs (
    .clock(clk), .reset(reset), .clear_prev(zero),
    .in_real_rd_en(cs_rd_en_r), .in_real_empty(c_empty), .in_real_dout(c_dout_re),
    .in_imag_rd_en(cs_rd_en_i), .in_imag_empty(c_empty), .in_imag_dout(c_dout_im),
    .out_real_wr_en(cs_wr_en_r), .out_real_full(zero), .out_real_din(cs_out_re),
    .out_imag_wr_en(cs_wr_en_i), .out_imag_full(zero), .out_imag_din(cs_out_im),
    .out_ch(cs_out_ch));

  demod_conj_mult_mc #(.DATA_WIDTH(16), .QUANT_BITS(10), .NUM_CH(1), .SATURATE(0)) dut_cw (
    .clock(clk), .reset(reset), .clear_prev(zero),
    .in_real_rd_en(cw_rd_en_r), .in_real_empty(c_empty), .in_real_dout(c_dout_re),
    .in_imag_rd_en(cw_rd_en_i), .in_imag_empty(c_empty), .in_imag_dout(c_dout_im),
    .out_real_wr_en(cw_wr_en_r), .out_real_full(zero), .out_real_din(cw_out_re),
    .out_imag_wr_en(cw_wr_en_i), .out_imag_full(zero), .out_imag_din(cw_out_im),
    .out_ch(cw_out_ch));

  // FIFO pop models and result logging
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_rd_en_r) begin
      a_rd_cyc[a_rd[5:0]] <= cyc;
      a_rd <= a_rd + 1;
    end
    if (a_wr_en_r && a_wr_en_i) begin
      a_res_re[a_n[5:0]]  <= a_out_re;
      a_res_im[a_n[5:0]]  <= a_out_im;
      a_res_cyc[a_n[5:0]] <= cyc;
      a_n <= a_n + 1;
    end
    if (b_rd_en_r) b_rd <= b_rd + 1;
    if (b_wr_en_r && b_wr_en_i) begin
      b_res_re[b_n[5:0]] <= b_out_re;
      b_res_im[b_n[5:0]] <= b_out_im;
      b_res_ch[b_n[5:0]] <= b_out_ch;
      b_n <= b_n + 1;
    end
    if (cs_rd_en_r) c_rd <= c_rd + 1;
    if (cs_wr_en_r) begin
      cs_res_re[c_n[2:0]] <= cs_out_re;
      cs_res_im[c_n[2:0]] <= cs_out_im;
      cw_res_re[c_n[2:0]] <= cw_out_re;
      cw_res_im[c_n[2:0]] <= cw_out_im;
      c_n <= c_n + 1;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic a_push(input int re, input int im);
    a_src_re[a_wr[5:0]] = re;
    a_src_im[a_wr[5:0]] = im;
    a_wr = a_wr + 1;
  endtask

  task automatic b_push(input int re, input int im);
    b_src_re[b_wr[5:0]] = re;
    b_src_im[b_wr[5:0]] = im;
    b_wr = b_wr + 1;
  endtask

  int t1_re [6] = '{1024, 0, 1, -1, -1536, 3};
  int t1_im [6] = '{0, 1024, 0, 0, 2048, -5};
  int t1_xr [6] = '{0, 0, 0, 0, 1, -14};
  int t1_xi [6] = '{0, 1024, -1, 0, -2, 1};
  int bp_re [4] = '{1024, 2048, 10, 512};
  int bp_im [4] = '{1024, 0, 20, -512};
  int bp_xr [4] = '{-2, 2048, 20, -5};
  int bp_xi [4] = '{8, -2048, 40, -15};
  int b_xr [4]  = '{0, 0, 0, 0};
  int b_xi [4]  = '{0, 0, 1024, -1024};

  initial begin
    int n0, rd0, n1;
    // Reset state, with samples already waiting in A's input FIFO
    for (int k = 0; k < 6; k++) a_push(t1_re[k], t1_im[k]);
    repeat (3) @(negedge clk);
    check("rst_rd_en", a_rd_en_r, 0);
    check("rst_wr_en", a_wr_en_r, 0);
    check("rst_out_re", a_out_re, 0);
    check("rst_out_im", a_out_im, 0);
    check("rst_out_ch", a_out_ch, 0);
    reset = 1'b0;

    // A: streaming, latency, truncation toward zero
    for (int k = 0; k < 40 && a_n < 6; k++) @(negedge clk);
    check("t1_count", a_n, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t1_re%0d", k), a_res_re[k], t1_xr[k]);
      check($sformatf("t1_im%0d", k), a_res_im[k], t1_xi[k]);
      check($sformatf("t1_lat%0d", k), a_res_cyc[k] - a_rd_cyc[k], 1);
      check($sformatf("t1_rate%0d", k), a_res_cyc[k] - a_res_cyc[0], k);
    end

    // A: back-pressure on the imag output FIFO
    a_full_i = 1'b1;
    rd0 = a_rd;
    n0 = a_n;
    for (int k = 0; k < 4; k++) a_push(bp_re[k], bp_im[k]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_wr_r%0d", k), a_wr_en_r, 0);
      check($sformatf("bp_wr_i%0d", k), a_wr_en_i, 0);
      check($sformatf("bp_hold_re%0d", k), a_out_re, bp_xr[0]);
      check($sformatf("bp_hold_im%0d", k), a_out_im, bp_xi[0]);
      check($sformatf("bp_pops%0d", k), a_rd - rd0, 1);
    end
    a_full_i = 1'b0;
    for (int k = 0; k < 40 && a_n < n0 + 4; k++) @(negedge clk);
    check("bp_count", a_n - n0, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_re%0d", k), a_res_re[n0 + k], bp_xr[k]);
      check($sformatf("bp_im%0d", k), a_res_im[n0 + k], bp_xi[k]);
      check($sformatf("bp_rate%0d", k), a_res_cyc[n0 + k] - a_res_cyc[n0], k);
    end

    // A: reset while a result is pending
    a_full_r = 1'b1;
    a_push(1024, 0);
    @(negedge clk);
    check("mr_pending_re", a_out_re, 512);
    check("mr_pending_im", a_out_im, 512);
    n1 = a_n;
    reset = 1'b1;
    #1;
    check("mr_wr_en", a_wr_en_r, 0);
    check("mr_rd_en", a_rd_en_r, 0);
    check("mr_out_re", a_out_re, 0);
    check("mr_out_im", a_out_im, 0);
    check("mr_out_ch", a_out_ch, 0);
    @(negedge clk);
    reset = 1'b0;
    a_full_r = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_no_write", a_n, n1);
    a_push(1024, 1024);
    for (int k = 0; k < 40 && a_n < n1 + 1; k++) @(negedge clk);
    check("mr_count", a_n - n1, 1);
    check("mr_prev_re", a_res_re[n1], 0);
    check("mr_prev_im", a_res_im[n1], 0);

    // B: two interleaved channels
    b_push(1024, 0);
    b_push(0, 1024);
    b_push(0, 1024);
    b_push(1024, 0);
    for (int k = 0; k < 40 && b_n < 4; k++) @(negedge clk);
    check("ch_count", b_n, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ch_re%0d", k), b_res_re[k], b_xr[k]);
      check($sformatf("ch_im%0d", k), b_res_im[k], b_xi[k]);
      check($sformatf("ch_id%0d", k), b_res_ch[k], k % 2);
    end
    b_push(2048, 0);
    for (int k = 0; k < 40 && b_n < 5; k++) @(negedge clk);
    check("cl_pre_im", b_res_im[4], -2048);
    check("cl_pre_ch", b_res_ch[4], 0);

    // B: clear_prev coincident with an accept on channel 1
    b_clear = 1'b1;
    b_push(512, 256);
    @(negedge clk);
    b_clear = 1'b0;
    for (int k = 0; k < 40 && b_n < 6; k++) @(negedge clk);
    check("cl_count", b_n, 6);
    check("cl_re", b_res_re[5], 0);
    check("cl_im", b_res_im[5], 0);
    check("cl_ch", b_res_ch[5], 0);
    b_push(1024, 1024);
    for (int k = 0; k < 40 && b_n < 7; k++) @(negedge clk);
    check("cl_next_re", b_res_re[6], 0);
    check("cl_next_im", b_res_im[6], 0);
    check("cl_next_ch", b_res_ch[6], 1);
    b_push(1024, 0);
    for (int k = 0; k < 40 && b_n < 8; k++) @(negedge clk);
    check("cl_kept_re", b_res_re[7], 512);
    check("cl_kept_im", b_res_im[7], -256);
    check("cl_kept_ch", b_res_ch[7], 0);

    // C: 16-bit extreme operands, saturate versus wrap
    for (int k = 0; k < 2; k++) begin
      c_src_re[c_wr[2:0]] = 16'sh7FFF;
      c_src_im[c_wr[2:0]] = 16'sh8000;
      c_wr = c_wr + 1;
    end
    for (int k = 0; k < 40 && c_n < 2; k++) @(negedge clk);
    check("sat_count", c_n, 2);
    check("sat_first_re", cs_res_re[0], 0);
    check("sat_re", cs_res_re[1], 32767);
    check("sat_im", cs_res_im[1], 0);
    check("wrap_re", cw_res_re[1], -64);
    check("wrap_im", cw_res_im[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
